// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with valid/ready output stage.
// Ports: iCLK, iRST_N, iFlush, iValid/oReady in, oValid/iReady out,
//   iInstrucao, iPC, iTag -> oImm, oFmt, oTag, oTarget (IMMGEN_TARGET_EN).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iFlush,
    input  logic             iValid,
    output logic             oReady,
    input  logic [31:0]      iInstrucao,
    input  logic [XLEN-1:0]  iPC,
    input  logic [TAG_W-1:0] iTag,
    output logic             oValid,
    input  logic             iReady,
    output logic [XLEN-1:0]  oImm,
    output logic [2:0]       oFmt,
    output logic [TAG_W-1:0] oTag
`ifdef IMMGEN_TARGET_EN
    ,
    output logic [XLEN-1:0]  oTarget
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
`ifdef IMMGEN_TARGET_EN
        logic [XLEN-1:0]  tgt;
`endif
    } entry_t;

    logic [6:0]      opc;
    logic [31:0]     ins;
    logic [31:0]     raw;
    fmt_e            fmt;
    logic [XLEN-1:0] imm_x;
    entry_t          din;

    assign ins = iInstrucao;
    assign opc = iInstrucao[6:0];

    // Every format is built as a 32-bit value whose bit 31 is the
    // sign (zero for Z), so one extension step covers all of them.
    always_comb begin
        raw = '0;
        fmt = FMT_NONE;
        unique case (opc)
            OP_LOAD, OP_IMM, OP_JALR: begin
                raw = {{20{ins[31]}}, ins[31:20]};
                fmt = FMT_I;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    raw = {{20{ins[31]}}, ins[31:20]};
                    fmt = FMT_I;
                end
            end
            OP_STORE: begin
                raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                fmt = FMT_S;
            end
            OP_BRANCH: begin
                raw = {{19{ins[31]}}, ins[31], ins[7],
                       ins[30:25], ins[11:8], 1'b0};
                fmt = FMT_B;
            end
            OP_JAL: begin
                raw = {{11{ins[31]}}, ins[31], ins[19:12],
                       ins[20], ins[30:21], 1'b0};
                fmt = FMT_J;
            end
            OP_LUI, OP_AUIPC: begin
                raw = {ins[31:12], 12'b0};
                fmt = FMT_U;
            end
            OP_SYSTEM: begin
                if (ins[14]) begin
                    raw = {27'b0, ins[19:15]};
                    fmt = FMT_Z;
                end else begin
                    raw = {{20{ins[31]}}, ins[31:20]};
                    fmt = FMT_I;
                end
            end
            default: begin
                raw = '0;
                fmt = FMT_NONE;
            end
        endcase
    end

    always_comb begin
        imm_x       = {XLEN{raw[31]}};
        imm_x[31:0] = raw;
    end

    always_comb begin
        din     = '0;
        din.imm = imm_x;
        din.fmt = fmt;
        din.tag = iTag;
`ifdef IMMGEN_TARGET_EN
        if (fmt == FMT_B || fmt == FMT_J || opc == OP_AUIPC)
            din.tgt = iPC + imm_x;
`endif
    end

`ifndef IMMGEN_TARGET_EN
    logic unused_pc;
    assign unused_pc = ^iPC;
`endif

    entry_t out_q;
    entry_t skid_q;
    logic   out_v;
    logic   skid_v;
    logic   rdy_q;
    logic   in_fire;
    logic   out_fire;
    logic   out_v_n;
    logic   skid_v_n;
    logic   ld_out_din;
    logic   ld_out_skid;
    logic   ld_skid;

    assign in_fire  = iValid & rdy_q;
    assign out_fire = out_v & iReady;

    always_comb begin
        out_v_n     = out_v;
        skid_v_n    = skid_v;
        ld_out_din  = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        if (iFlush) begin
            out_v_n  = 1'b0;
            skid_v_n = 1'b0;
        end else if (!out_v || out_fire) begin
            if (skid_v) begin
                ld_out_skid = 1'b1;
                skid_v_n    = 1'b0;
                out_v_n     = 1'b1;
            end else begin
                ld_out_din = in_fire;
                out_v_n    = in_fire;
            end
        end else if (in_fire) begin
            ld_skid  = 1'b1;
            skid_v_n = 1'b1;
        end
    end

    // Ready is a flop so it never depends on iReady in the same cycle;
    // it is held low during reset and rises on the first edge after.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            out_q  <= '0;
            skid_q <= '0;
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            out_v  <= out_v_n;
            skid_v <= skid_v_n;
            rdy_q  <= ~skid_v_n;
            if (ld_out_skid)
                out_q <= skid_q;
            else if (ld_out_din)
                out_q <= din;
            if (ld_skid)
                skid_q <= din;
        end
    end

    assign oReady = rdy_q;
    assign oValid = out_v;
    assign oImm   = out_q.imm;
    assign oFmt   = out_q.fmt;
    assign oTag   = out_q.tag;
`ifdef IMMGEN_TARGET_EN
    assign oTarget = out_q.tgt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Both instances share stimulus; each output is checked against constants.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  tag;

    logic        rdy32, v32, rdy64, v64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;
    logic [4:0]  tag32, tag64;
`ifdef IMMGEN_TARGET_EN
    logic [31:0] tgt32;
    logic [63:0] tgt64;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
        .iCLK(clk), .iRST_N(rst_n), .iFlush(flush),
        .iValid(valid), .oReady(rdy32),
        .iInstrucao(instr), .iPC(pc[31:0]), .iTag(tag),
        .oValid(v32), .iReady(ready),
        .oImm(imm32), .oFmt(fmt32), .oTag(tag32)
`ifdef IMMGEN_TARGET_EN
        , .oTarget(tgt32)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
        .iCLK(clk), .iRST_N(rst_n), .iFlush(flush),
        .iValid(valid), .oReady(rdy64),
        .iInstrucao(instr), .iPC(pc), .iTag(tag),
        .oValid(v64), .iReady(ready),
        .oImm(imm64), .oFmt(fmt64), .oTag(tag64)
`ifdef IMMGEN_TARGET_EN
        , .oTarget(tgt64)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Present one instruction and advance to the next falling edge.
    task automatic put(input logic [31:0] i, input logic [4:0] t,
                       input logic [63:0] p);
        valid = 1'b1;
        instr = i;
        tag   = t;
        pc    = p;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        ready = 1'b1;
        instr = '0;
        pc    = '0;
        tag   = '0;

        @(negedge clk);
        @(negedge clk);
        chk("rst v32",   64'(v32),   64'h0);
        chk("rst imm32", 64'(imm32), 64'h0);
        chk("rst fmt32", 64'(fmt32), 64'h0);
        chk("rst tag32", 64'(tag32), 64'h0);
        chk("rst v64",   64'(v64),   64'h0);
        chk("rst imm64", imm64,      64'h0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy32 after rst", 64'(rdy32), 64'h1);
        chk("rdy64 after rst", 64'(rdy64), 64'h1);

        put(32'hFFF00093, 5'd1, 64'h0);
        chk("addi v32",   64'(v32),   64'h1);
        chk("addi imm32", 64'(imm32), 64'hFFFFFFFF);
        chk("addi fmt32", 64'(fmt32), 64'd1);
        chk("addi tag32", 64'(tag32), 64'd1);
        chk("addi imm64", imm64,      64'hFFFFFFFFFFFFFFFF);
`ifdef IMMGEN_TARGET_EN
        chk("addi tgt32", 64'(tgt32), 64'h0);
`endif

        put(32'h800000B7, 5'd2, 64'h0);
        chk("lui imm64",  imm64,      64'hFFFFFFFF80000000);
        chk("lui fmt64",  64'(fmt64), 64'd4);
        chk("lui imm32",  64'(imm32), 64'h80000000);

        put(32'h0010009B, 5'd3, 64'h0);
        chk("addiw imm64", imm64,      64'h1);
        chk("addiw fmt64", 64'(fmt64), 64'd1);
        chk("addiw fmt32", 64'(fmt32), 64'd0);
        chk("addiw imm32", 64'(imm32), 64'h0);

        put(32'hFE000EE3, 5'd4, 64'h100);
        chk("beq imm32", 64'(imm32), 64'hFFFFFFFC);
        chk("beq imm64", imm64,      64'hFFFFFFFFFFFFFFFC);
        chk("beq fmt32", 64'(fmt32), 64'd3);
`ifdef IMMGEN_TARGET_EN
        chk("beq tgt32", 64'(tgt32), 64'hFC);
        chk("beq tgt64", tgt64,      64'hFC);
`endif

        put(32'h3401D073, 5'd5, 64'h0);
        chk("csrrwi fmt32", 64'(fmt32), 64'd6);
        chk("csrrwi imm32", 64'(imm32), 64'h3);
        chk("csrrwi imm64", imm64,      64'h3);

        put(32'h0000007F, 5'd6, 64'h0);
        chk("unk fmt32", 64'(fmt32), 64'd0);
        chk("unk imm32", 64'(imm32), 64'h0);
        chk("unk tag32", 64'(tag32), 64'd6);

        put(32'hFE20AC23, 5'd7, 64'h0);
        chk("sw imm32", 64'(imm32), 64'hFFFFFFF8);
        chk("sw fmt32", 64'(fmt32), 64'd2);

        put(32'h0010006F, 5'd8, 64'h1000);
        chk("jal imm64", imm64,      64'h800);
        chk("jal fmt64", 64'(fmt64), 64'd5);
`ifdef IMMGEN_TARGET_EN
        chk("jal tgt64", tgt64,      64'h1800);
`endif

        put(32'h00001297, 5'd9, 64'h200);
        chk("auipc imm32", 64'(imm32), 64'h1000);
        chk("auipc fmt32", 64'(fmt32), 64'd4);
`ifdef IMMGEN_TARGET_EN
        chk("auipc tgt32", 64'(tgt32), 64'h1200);
`endif

        put(32'h30529073, 5'd10, 64'h0);
        chk("csrw fmt32", 64'(fmt32), 64'd1);
        chk("csrw imm32", 64'(imm32), 64'h305);

        put(32'h8000A103, 5'd11, 64'h0);
        chk("lw imm32", 64'(imm32), 64'hFFFFF800);
        chk("lw imm64", imm64,      64'hFFFFFFFFFFFFF800);

        valid = 1'b0;
        @(negedge clk);
        chk("drain v32", 64'(v32), 64'h0);

        // Backpressure: A, B, C back-to-back, downstream stalls.
        put(32'h00100093, 5'd12, 64'h0);
        ready = 1'b0;
        put(32'h00200093, 5'd13, 64'h0);
        chk("bp hold tagA", 64'(tag32), 64'd12);
        put(32'h00300093, 5'd14, 64'h0);
        chk("bp hold v",    64'(v32),   64'h1);
        chk("bp hold tagA2", 64'(tag32), 64'd12);
        chk("bp hold immA", 64'(imm32), 64'h1);
        chk("bp rdy low",   64'(rdy32), 64'h0);
        chk("bp rdy64 low", 64'(rdy64), 64'h0);
        ready = 1'b1;
        @(negedge clk);
        chk("bp out tagB", 64'(tag32), 64'd13);
        chk("bp out immB", 64'(imm32), 64'h2);
        chk("bp rdy back", 64'(rdy32), 64'h1);
        @(negedge clk);
        chk("bp out tagC", 64'(tag32), 64'd14);
        chk("bp out immC", 64'(imm64), 64'h3);
        valid = 1'b0;
        @(negedge clk);
        chk("bp empty", 64'(v32), 64'h0);

        // Flush with both entries full and a new input presented.
        ready = 1'b0;
        put(32'h00500093, 5'd20, 64'h0);
        put(32'h00600093, 5'd21, 64'h0);
        chk("fl full rdy", 64'(rdy32), 64'h0);
        chk("fl full v",   64'(v32),   64'h1);
        instr = 32'h00700093;
        tag   = 5'd22;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        chk("fl v32",   64'(v32),   64'h0);
        chk("fl v64",   64'(v64),   64'h0);
        chk("fl rdy32", 64'(rdy32), 64'h1);
        ready = 1'b1;
        @(negedge clk);
        chk("fl gone", 64'(v32), 64'h0);
        put(32'h00800093, 5'd23, 64'h0);
        chk("fl next tag", 64'(tag32), 64'd23);
        chk("fl next imm", 64'(imm32), 64'h8);

        // Asynchronous reset mid-stream.
        put(32'h00900093, 5'd24, 64'h0);
        chk("pre rst v", 64'(v32), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst v32",   64'(v32),   64'h0);
        chk("async rst v64",   64'(v64),   64'h0);
        chk("async rst imm32", 64'(imm32), 64'h0);
        chk("async rst tag32", 64'(tag32), 64'h0);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("re-rst rdy", 64'(rdy32), 64'h1);
        chk("re-rst v",   64'(v32),   64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
